// File: rtl/ddr_cmd_sequencer.sv
// DDR command sequencer: takes one scheduler request per valid/ready handshake,
// enforces bank legality and per-bank/global timing, and drives the PHY command
// pins one cycle after acceptance. Open banks are tracked with a bit per bank.
module ddr_cmd_sequencer #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14,
  parameter int COL_W     = 10,
  parameter int T_INIT    = 4,
  parameter int T_ZQINIT  = 16,
  parameter int T_MOD     = 4,
  parameter int T_RFC     = 20,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 8,
  parameter int T_AP      = 4,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cke,
  output logic             cs,
  output logic             ras,
  output logic             cas,
  output logic             we,
  output logic [BA_W-1:0]  ba,
  output logic [ROW_W-1:0] addr,
  output logic             err,
  output logic [2:0]       state
);

  localparam int CW = 8;

  localparam logic [2:0] ST_INIT = 3'd0, ST_ZQWAIT = 3'd1, ST_IDLE = 3'd2,
                         ST_BUSY = 3'd3, ST_SREF = 3'd4, ST_PDOWN = 3'd5;

  localparam logic [3:0] CMD_NOP = 4'd0, CMD_MRS = 4'd1, CMD_REF = 4'd2, CMD_ZQCL = 4'd3,
                         CMD_ACT = 4'd4, CMD_WR = 4'd5, CMD_RD = 4'd6, CMD_WRA = 4'd7,
                         CMD_RDA = 4'd8, CMD_PRE = 4'd9, CMD_PREA = 4'd10, CMD_SRE = 4'd11,
                         CMD_SRX = 4'd12, CMD_PDE = 4'd13, CMD_PDX = 4'd14;

  // Pin patterns ordered {cs, ras, cas, we}
  localparam logic [3:0] PIN_NOP = 4'b0111, PIN_DES = 4'b1111, PIN_ACT = 4'b0011,
                         PIN_RD = 4'b0101, PIN_WR = 4'b0100, PIN_PRE = 4'b0010,
                         PIN_REF = 4'b0001, PIN_MRS = 4'b0000, PIN_ZQ = 4'b0110;

  logic [2:0]       state_r, nxt_state_s;
  logic [CW-1:0]    init_cnt_r, nxt_init_s, gcnt_r, nxt_gcnt_s;
  logic             cke_r, nxt_cke_s, err_r;
  logic [3:0]       pin_r, nxt_pin_s;
  logic [BA_W-1:0]  ba_r, nxt_ba_s;
  logic [ROW_W-1:0] addr_r, nxt_addr_s, col_addr_s;
  logic [NUM_BANKS-1:0] open_r;
  logic [CW-1:0]    t_rcd_r [NUM_BANKS];
  logic [CW-1:0]    t_ras_r [NUM_BANKS];
  logic [CW-1:0]    t_rp_r  [NUM_BANKS];
  logic             legal_s, timing_ok_s, silent_s, prea_ok_s;
  logic             accept_state_s, fire_s, issue_s, auto_pre_s;

  // Saturating down-counter step shared by every timing counter.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  // PREA may only go once every currently open bank has satisfied its ACT-to-PRE time.
  always_comb begin
    prea_ok_s = 1'b1;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (open_r[i] && (t_ras_r[i] != '0)) prea_ok_s = 1'b0;
      else prea_ok_s = prea_ok_s;
    end
  end

  // Legality (drop with ERR) is decided independently of timing (stall).
  always_comb begin
    legal_s     = 1'b0;
    timing_ok_s = 1'b1;
    silent_s    = (req_cmd == CMD_NOP);
    case (state_r)
      ST_ZQWAIT: legal_s = (req_cmd == CMD_ZQCL);
      ST_SREF:   legal_s = (req_cmd == CMD_SRX);
      ST_PDOWN:  legal_s = (req_cmd == CMD_PDX);
      ST_IDLE: begin
        case (req_cmd)
          CMD_MRS, CMD_REF, CMD_ZQCL, CMD_SRE: legal_s = ~|open_r;
          CMD_ACT: begin
            legal_s     = ~open_r[req_bank];
            timing_ok_s = (t_rp_r[req_bank] == '0);
          end
          CMD_WR, CMD_RD, CMD_WRA, CMD_RDA: begin
            legal_s     = open_r[req_bank];
            timing_ok_s = (t_rcd_r[req_bank] == '0);
          end
          CMD_PRE: begin
            legal_s     = open_r[req_bank];
            timing_ok_s = (t_ras_r[req_bank] == '0);
          end
          CMD_PREA: begin
            legal_s     = 1'b1;
            timing_ok_s = prea_ok_s;
          end
          CMD_PDE: legal_s = 1'b1;
          default: legal_s = 1'b0;
        endcase
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign accept_state_s = (state_r == ST_ZQWAIT) || (state_r == ST_IDLE) ||
                          (state_r == ST_SREF) || (state_r == ST_PDOWN);
  assign req_ready  = accept_state_s && !(req_valid && legal_s && !timing_ok_s);
  assign fire_s     = req_valid && req_ready;
  assign issue_s    = fire_s && legal_s;
  assign auto_pre_s = (req_cmd == CMD_RDA) || (req_cmd == CMD_WRA);

  // Top-level state, init/busy counters and CKE for the next cycle.
  always_comb begin
    nxt_state_s = state_r;
    nxt_init_s  = init_cnt_r;
    nxt_gcnt_s  = gcnt_r;
    nxt_cke_s   = cke_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r >= CW'(T_INIT - 1)) begin
          nxt_state_s = ST_ZQWAIT;
          nxt_cke_s   = 1'b1;
          nxt_init_s  = '0;
        end else begin
          nxt_init_s = init_cnt_r + CW'(1);
        end
      end
      ST_BUSY: begin
        if (gcnt_r <= CW'(1)) begin
          nxt_state_s = ST_IDLE;
          nxt_gcnt_s  = '0;
        end else begin
          nxt_gcnt_s = gcnt_r - CW'(1);
        end
      end
      ST_ZQWAIT, ST_IDLE, ST_SREF, ST_PDOWN: begin
        if (issue_s) begin
          case (req_cmd)
            CMD_ZQCL: begin nxt_state_s = ST_BUSY; nxt_gcnt_s = CW'(T_ZQINIT); end
            CMD_MRS:  begin nxt_state_s = ST_BUSY; nxt_gcnt_s = CW'(T_MOD); end
            CMD_REF:  begin nxt_state_s = ST_BUSY; nxt_gcnt_s = CW'(T_RFC); end
            CMD_SRE:  begin nxt_state_s = ST_SREF; nxt_cke_s = 1'b0; end
            CMD_SRX:  begin nxt_state_s = ST_BUSY; nxt_gcnt_s = CW'(T_RFC); nxt_cke_s = 1'b1; end
            CMD_PDE:  begin nxt_state_s = ST_PDOWN; nxt_cke_s = 1'b0; end
            CMD_PDX:  begin nxt_state_s = ST_IDLE; nxt_cke_s = 1'b1; end
            default:  nxt_state_s = state_r;
          endcase
        end else begin
          nxt_state_s = state_r;
        end
      end
      default: begin
        nxt_state_s = ST_INIT;
        nxt_cke_s   = 1'b0;
      end
    endcase
  end

  // Pin values for the cycle after acceptance; idle cycles show NOP or deselect by CKE.
  always_comb begin
    col_addr_s              = '0;
    col_addr_s[COL_W-1:0]   = req_col;
    nxt_pin_s               = nxt_cke_s ? PIN_NOP : PIN_DES;
    nxt_ba_s                = '0;
    nxt_addr_s              = '0;
    if (issue_s) begin
      case (req_cmd)
        CMD_MRS:  begin nxt_pin_s = PIN_MRS; nxt_ba_s = req_bank; nxt_addr_s = req_row; end
        CMD_REF:  nxt_pin_s = PIN_REF;
        CMD_SRE:  nxt_pin_s = PIN_REF;
        CMD_ZQCL: nxt_pin_s = PIN_ZQ;
        CMD_ACT:  begin nxt_pin_s = PIN_ACT; nxt_ba_s = req_bank; nxt_addr_s = req_row; end
        CMD_WR, CMD_WRA: begin
          nxt_pin_s      = PIN_WR;
          nxt_ba_s       = req_bank;
          nxt_addr_s     = col_addr_s;
          nxt_addr_s[10] = auto_pre_s;
        end
        CMD_RD, CMD_RDA: begin
          nxt_pin_s      = PIN_RD;
          nxt_ba_s       = req_bank;
          nxt_addr_s     = col_addr_s;
          nxt_addr_s[10] = auto_pre_s;
        end
        CMD_PRE:  begin nxt_pin_s = PIN_PRE; nxt_ba_s = req_bank; end
        CMD_PREA: begin nxt_pin_s = PIN_PRE; nxt_addr_s[10] = 1'b1; end
        default:  nxt_pin_s = nxt_cke_s ? PIN_NOP : PIN_DES;
      endcase
    end else begin
      nxt_pin_s = nxt_cke_s ? PIN_NOP : PIN_DES;
    end
  end

  // Registered FSM, counters and every PHY-facing output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      gcnt_r     <= '0;
      cke_r      <= 1'b0;
      pin_r      <= PIN_DES;
      ba_r       <= '0;
      addr_r     <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      init_cnt_r <= nxt_init_s;
      gcnt_r     <= nxt_gcnt_s;
      cke_r      <= nxt_cke_s;
      pin_r      <= nxt_pin_s;
      ba_r       <= nxt_ba_s;
      addr_r     <= nxt_addr_s;
      err_r      <= fire_s && !legal_s && !silent_s;
    end
  end

  // Per-bank open flag and rcd/ras/rp counters; auto-precharge closes the bank at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_r <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        t_rcd_r[i] <= '0;
        t_ras_r[i] <= '0;
        t_rp_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        t_rcd_r[i] <= sat_dec(t_rcd_r[i]);
        t_ras_r[i] <= sat_dec(t_ras_r[i]);
        t_rp_r[i]  <= sat_dec(t_rp_r[i]);
        if (issue_s && (req_cmd == CMD_ACT) && (req_bank == BA_W'(i))) begin
          open_r[i]  <= 1'b1;
          t_rcd_r[i] <= CW'(T_RCD);
          t_ras_r[i] <= CW'(T_RAS);
        end else if (issue_s && (((req_cmd == CMD_PRE) && (req_bank == BA_W'(i))) ||
                                 ((req_cmd == CMD_PREA) && open_r[i]))) begin
          open_r[i] <= 1'b0;
          t_rp_r[i] <= CW'(T_RP);
        end else if (issue_s && auto_pre_s && (req_bank == BA_W'(i))) begin
          open_r[i] <= 1'b0;
          t_rp_r[i] <= CW'(T_AP + T_RP);
        end else begin
          open_r[i] <= open_r[i];
        end
      end
    end
  end

  assign cke   = cke_r;
  assign cs    = pin_r[3];
  assign ras   = pin_r[2];
  assign cas   = pin_r[1];
  assign we    = pin_r[0];
  assign ba    = ba_r;
  assign addr  = addr_r;
  assign err   = err_r;
  assign state = state_r;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer with hand-computed expectations.
module tb_ddr_cmd_sequencer;

  localparam logic [3:0] C_NOP = 4'd0, C_MRS = 4'd1, C_REF = 4'd2, C_ZQ = 4'd3, C_ACT = 4'd4,
                         C_WR = 4'd5, C_RD = 4'd6, C_RDA = 4'd8, C_PREA = 4'd10,
                         C_SRE = 4'd11, C_SRX = 4'd12, C_PDE = 4'd13, C_PDX = 4'd14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [2:0]  req_bank;
  logic [13:0] req_row;
  logic [9:0]  req_col;
  logic        cke, cs, ras, cas, we, err;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [2:0]  state;
  logic [3:0]  pins;

  int errors = 0;
  int checks = 0;
  int n;

  assign pins = {cs, ras, cas, we};

  always #5 clk = ~clk;

  ddr_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cke(cke), .cs(cs), .ras(ras), .cas(cas), .we(we), .ba(ba), .addr(addr),
    .err(err), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [13:0] r,
                       input logic [9:0] col);
    req_valid = 1'b1;
    req_cmd   = c;
    req_bank  = b;
    req_row   = r;
    req_col   = col;
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_cmd   = C_NOP;
    req_bank  = 3'd0;
    req_row   = 14'd0;
    req_col   = 10'd0;
    #1;
  endtask

  // Counts consecutive cycles with req_ready low, bounded so a stuck DUT still ends.
  task automatic count_low(output int cnt);
    cnt = 0;
    while ((req_ready !== 1'b1) && (cnt < 200)) begin
      cnt++;
      tick();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cke"},   {31'd0, cke}, 32'd0);
    chk({tag, "_pins"},  {28'd0, pins}, 32'h0000000F);
    chk({tag, "_ba"},    {29'd0, ba}, 32'd0);
    chk({tag, "_addr"},  {18'd0, addr}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
  endtask

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_n = 1'b0;
    idle_req();
    repeat (2) tick();
    check_reset("por");

    // Init: CKE stays low for T_INIT cycles after release
    reset_n = 1'b1;
    repeat (3) tick();
    chk("init_cke_low", {31'd0, cke}, 32'd0);
    chk("init_state", {29'd0, state}, 32'd0);
    tick();
    chk("init_cke_high", {31'd0, cke}, 32'd1);
    chk("zqwait_state", {29'd0, state}, 32'd1);
    chk("zqwait_nop", {28'd0, pins}, 32'h7);

    // Anything but ZQCL in ZQWAIT is dropped with ERR
    drive(C_RD, 3'd0, 14'd0, 10'd0);
    chk("zqwait_ready", {31'd0, req_ready}, 32'd1);
    tick();
    idle_req();
    chk("zqwait_rd_err", {31'd0, err}, 32'd1);
    chk("zqwait_rd_pins", {28'd0, pins}, 32'h7);
    tick();
    chk("err_pulse_end", {31'd0, err}, 32'd0);

    // ZQCL: pins 0110, ready low for T_ZQINIT cycles
    drive(C_ZQ, 3'd0, 14'd0, 10'd0);
    tick();
    idle_req();
    chk("zq_pins", {28'd0, pins}, 32'h6);
    chk("zq_busy", {29'd0, state}, 32'd3);
    count_low(n);
    chk("zq_busy_len", n, 32'd16);
    chk("idle_state", {29'd0, state}, 32'd2);

    // ACT b3, RD b3 immediately: stalls T_RCD cycles
    drive(C_ACT, 3'd3, 14'h1A5, 10'd0);
    chk("act_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("act_pins", {28'd0, pins}, 32'h3);
    chk("act_ba", {29'd0, ba}, 32'd3);
    chk("act_addr", {18'd0, addr}, 32'h1A5);
    drive(C_RD, 3'd3, 14'd0, 10'h040);
    chk("rd_stall", {31'd0, req_ready}, 32'd0);
    count_low(n);
    chk("rd_stall_len", n, 32'd3);
    tick();
    chk("rd_pins", {28'd0, pins}, 32'h5);
    chk("rd_ba", {29'd0, ba}, 32'd3);
    chk("rd_addr", {18'd0, addr}, 32'h040);

    // RDA closes b3 with rp = T_AP + T_RP = 7
    drive(C_RDA, 3'd3, 14'd0, 10'h007);
    tick();
    chk("rda_pins", {28'd0, pins}, 32'h5);
    chk("rda_addr", {18'd0, addr}, 32'h407);
    drive(C_ACT, 3'd3, 14'h010, 10'd0);
    chk("act_rp_stall", {31'd0, req_ready}, 32'd0);
    // A RD to the now-closed bank is illegal, so it is consumed despite the pending stall
    drive(C_RD, 3'd3, 14'd0, 10'd1);
    chk("rd_closed_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("rd_closed_err", {31'd0, err}, 32'd1);
    chk("rd_closed_pins", {28'd0, pins}, 32'h7);
    // One of the 7 rp cycles was spent on the RD, 6 remain
    drive(C_ACT, 3'd3, 14'h010, 10'd0);
    count_low(n);
    chk("act_rp_len", n, 32'd6);
    tick();
    chk("act2_pins", {28'd0, pins}, 32'h3);
    chk("act2_addr", {18'd0, addr}, 32'h010);

    // Open b0 and b5, then REF with open banks is illegal
    drive(C_ACT, 3'd0, 14'h022, 10'd0);
    chk("act_b0_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("act_b0_addr", {18'd0, addr}, 32'h022);
    drive(C_ACT, 3'd5, 14'h033, 10'd0);
    tick();
    chk("act_b5_ba", {29'd0, ba}, 32'd5);
    drive(C_REF, 3'd0, 14'd0, 10'd0);
    tick();
    chk("ref_open_err", {31'd0, err}, 32'd1);

    // PREA waits for the youngest ACT (b5, 7 more cycles of T_RAS)
    drive(C_PREA, 3'd0, 14'd0, 10'd0);
    count_low(n);
    chk("prea_stall_len", n, 32'd7);
    tick();
    chk("prea_pins", {28'd0, pins}, 32'h2);
    chk("prea_addr", {18'd0, addr}, 32'h400);

    // REF: pins 0001, ready low for T_RFC
    drive(C_REF, 3'd0, 14'd0, 10'd0);
    chk("ref_ready", {31'd0, req_ready}, 32'd1);
    tick();
    idle_req();
    chk("ref_pins", {28'd0, pins}, 32'h1);
    chk("ref_state", {29'd0, state}, 32'd3);
    count_low(n);
    chk("ref_busy_len", n, 32'd20);

    // Power-down keeps the open row
    drive(C_ACT, 3'd2, 14'h055, 10'd0);
    tick();
    chk("act_b2_pins", {28'd0, pins}, 32'h3);
    drive(C_PDE, 3'd0, 14'd0, 10'd0);
    tick();
    chk("pde_cke", {31'd0, cke}, 32'd0);
    chk("pde_pins", {28'd0, pins}, 32'hF);
    chk("pde_state", {29'd0, state}, 32'd5);
    drive(C_WR, 3'd2, 14'd0, 10'd9);
    chk("pd_wr_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("pd_wr_err", {31'd0, err}, 32'd1);
    chk("pd_wr_pins", {28'd0, pins}, 32'hF);
    drive(C_PDX, 3'd0, 14'd0, 10'd0);
    tick();
    chk("pdx_cke", {31'd0, cke}, 32'd1);
    chk("pdx_pins", {28'd0, pins}, 32'h7);
    chk("pdx_state", {29'd0, state}, 32'd2);
    drive(C_RD, 3'd2, 14'd0, 10'd3);
    chk("pdx_rd_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("pdx_rd_pins", {28'd0, pins}, 32'h5);
    chk("pdx_rd_ba", {29'd0, ba}, 32'd2);
    chk("pdx_rd_err", {31'd0, err}, 32'd0);

    // SRE with a bank open is illegal
    drive(C_SRE, 3'd0, 14'd0, 10'd0);
    tick();
    chk("sre_open_err", {31'd0, err}, 32'd1);
    chk("sre_open_state", {29'd0, state}, 32'd2);
    chk("sre_open_cke", {31'd0, cke}, 32'd1);
    drive(C_PREA, 3'd0, 14'd0, 10'd0);
    count_low(n);
    chk("prea2_stall_len", n, 32'd3);
    tick();
    chk("prea2_pins", {28'd0, pins}, 32'h2);

    // Self-refresh entry/exit
    drive(C_SRE, 3'd0, 14'd0, 10'd0);
    tick();
    chk("sre_pins", {28'd0, pins}, 32'h1);
    chk("sre_cke", {31'd0, cke}, 32'd0);
    chk("sre_state", {29'd0, state}, 32'd4);
    drive(C_SRX, 3'd0, 14'd0, 10'd0);
    tick();
    idle_req();
    chk("srx_cke", {31'd0, cke}, 32'd1);
    chk("srx_pins", {28'd0, pins}, 32'h7);
    chk("srx_state", {29'd0, state}, 32'd3);
    count_low(n);
    chk("srx_busy_len", n, 32'd20);

    // MRS, then reset in the middle of BUSY
    drive(C_MRS, 3'd1, 14'h123, 10'd0);
    tick();
    idle_req();
    chk("mrs_pins", {28'd0, pins}, 32'h0);
    chk("mrs_ba", {29'd0, ba}, 32'd1);
    chk("mrs_addr", {18'd0, addr}, 32'h123);
    tick();
    reset_n = 1'b0;
    #1;
    check_reset("busy_rst");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("busy_rel_cke", {31'd0, cke}, 32'd0);
    chk("busy_rel_pins", {28'd0, pins}, 32'hF);
    tick();
    chk("busy_rel_state", {29'd0, state}, 32'd1);
    chk("busy_rel_nop", {28'd0, pins}, 32'h7);

    // Reset while a RD is stalled: nothing issues after release
    drive(C_ZQ, 3'd0, 14'd0, 10'd0);
    tick();
    idle_req();
    count_low(n);
    chk("zq2_busy_len", n, 32'd16);
    drive(C_ACT, 3'd1, 14'h0AA, 10'd0);
    tick();
    drive(C_RD, 3'd1, 14'd0, 10'd2);
    chk("rd2_stall", {31'd0, req_ready}, 32'd0);
    tick();
    reset_n = 1'b0;
    #1;
    check_reset("stall_rst");
    idle_req();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("stall_rel_state", {29'd0, state}, 32'd1);
    chk("stall_rel_pins", {28'd0, pins}, 32'h7);
    chk("stall_rel_err", {31'd0, err}, 32'd0);
    chk("stall_rel_cke", {31'd0, cke}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
